mc_control_fsm: RTL and testbench
=================================

# mc_control_fsm

Multicycle control unit for the 32-bit MIPS-subset processor. It sequences every instruction through fetch, decode, execute, memory and write-back states. It drives the datapath mux selects, memory strobes and PC enable. It is the initiator of the register-file write port: it issues the register-write, memory-to-register and destination-select controls that the register file consumes. It sits between the instruction register's opcode/funct fields and the datapath.

## Interface
Parameters:
- `OPC_W`, 6, opcode field width.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `opcode`  in  6  IR[31:26].
- `zero`  in  1  ALU zero flag, valid in BRANCH.
- `mem_ready`  in  1  memory completes the access in this cycle.
- `pc_en`  out  1  PC load enable.
- `i_or_d`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `mem_read`  out  1  memory read strobe.
- `mem_write`  out  1  memory write strobe.
- `ir_write`  out  1  IR load enable.
- `reg_write`  out  1  register-file write enable.
- `mem_to_reg`  out  1  write-data select: 1 = memory data, 0 = ALU result.
- `reg_dst`  out  1  destination select: 1 = rd, 0 = rt.
- `alu_src_a`  out  1  ALU A select: 0 = PC, 1 = register A.
- `alu_src_b`  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = imm<<2.
- `alu_op`  out  2  ALU op: 00 = add, 01 = sub, 10 = funct.
- `pc_source`  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
- `instr_done`  out  1  one-cycle retire pulse.
- `illegal_op`  out  1  sticky illegal-opcode flag (see Configuration).

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- State register is 4 bits. Outputs are a Moore decode of the state, gated by `mem_ready` and `zero` where stated below.
- Any output not listed for a state is 0.
- **FETCH**
  - Outputs: `mem_read=1`, `alu_src_b=01`.
  - When `mem_ready=1`: `ir_write=1` and `pc_en=1`, then go to DECODE. Otherwise hold.
- **DECODE**
  - Outputs: `alu_src_b=11`.
  - Next state by opcode: lw/sw → MEMADR, R → EXEC, beq → BRANCH, addi → ADDIEX, j → JUMP, other → illegal handling.
- **MEMADR**
  - Outputs: `alu_src_a=1`, `alu_src_b=10`.
  - Next state: lw → MEMRD, sw → MEMWR.
- **MEMRD**
  - Outputs: `i_or_d=1`, `mem_read=1`.
  - Hold until `mem_ready`, then go to MEMWB.
- **MEMWB**
  - Outputs: `reg_write=1`, `mem_to_reg=1`, `reg_dst=0`, `instr_done=1`.
  - Next state: FETCH.
- **MEMWR**
  - Outputs: `i_or_d=1`, `mem_write=1`.
  - Hold until `mem_ready`. In the `mem_ready` cycle: `instr_done=1`, then go to FETCH.
- **EXEC**
  - Outputs: `alu_src_a=1`, `alu_op=10`.
  - Next state: ALUWB.
- **ALUWB**
  - Outputs: `reg_write=1`, `reg_dst=1`, `mem_to_reg=0`, `instr_done=1`.
  - Next state: FETCH.
- **BRANCH**
  - Outputs: `alu_src_a=1`, `alu_op=01`, `pc_source=01`, `pc_en=zero`, `instr_done=1`.
  - Next state: FETCH.
- **ADDIEX**
  - Outputs: `alu_src_a=1`, `alu_src_b=10`.
  - Next state: ADDIWB.
- **ADDIWB**
  - Outputs: `reg_write=1`, `reg_dst=0`, `mem_to_reg=0`, `instr_done=1`.
  - Next state: FETCH.
- **JUMP**
  - Outputs: `pc_source=10`, `pc_en=1`, `instr_done=1`.
  - Next state: FETCH.
- Write-port rules:
  - `reg_write` is exactly one cycle per lw/R/addi and never asserts for sw/beq/j.
  - `mem_to_reg` and `reg_dst` are valid whenever `reg_write=1`.
- `mem_read` and `mem_write` are never asserted together.

## Timing
- Reset (`rst=1`, asynchronous):
  - State goes to FETCH.
  - Every output is forced to 0 while `rst` is high, including `illegal_op`, which is cleared.
  - The first `mem_read` is seen in the first cycle after deassertion.
- Latency with zero-wait memory (`mem_ready` held at 1), counted from FETCH entry to the cycle after the `instr_done` pulse:
  - R: 4
  - lw: 5
  - sw: 4
  - beq: 3
  - j: 3
  - addi: 4
- Each cycle with `mem_ready=0` in FETCH, MEMRD or MEMWR adds one cycle. Strobes stay asserted and stable during the stall.
- `rst` asserted mid-instruction aborts it. No partial `reg_write` or `mem_write` pulse may appear after the reset edge.
- `opcode` is sampled only in DECODE and MEMADR; it may change at any other time without effect.

## Configuration
- `MC_ILLEGAL_TRAP_EN` defined:
  - An unknown opcode in DECODE enters a TRAP state.
  - TRAP holds indefinitely with all strobes 0 and `illegal_op=1`.
  - Only `rst` exits TRAP.
- `MC_ILLEGAL_TRAP_EN` undefined:
  - An unknown opcode is a NOP: DECODE → FETCH with `instr_done=1` in DECODE.
  - `illegal_op` is tied to 0.

## Structure
- Package `mc_ctrl_pkg` holds:
  - state encodings: FETCH=0 … JUMP=11, TRAP=12;
  - opcode constants;
  - `alu_op`, `alu_src_b` and `pc_source` code constants.
- Sub-module `mc_ctrl_decode` is purely combinational. It maps (state, `mem_ready`, `zero`) to the output vector. The top holds only the state register and the next-state logic.

## Test plan
- Zero-wait R-type (opcode 000000) → `reg_write=1`, `reg_dst=1`, `mem_to_reg=0` in exactly the 4th cycle after reset release; `instr_done` in the same cycle.
- lw with `mem_ready` low for 3 cycles in MEMRD → `mem_read`/`i_or_d` stable for 4 cycles, then one `reg_write` cycle with `mem_to_reg=1`, `reg_dst=0`; total 8 cycles.
- beq with `zero=1`, then a second beq with `zero=0` → `pc_en=1` with `pc_source=01` in the first BRANCH only; `pc_en=0` in the second; no `reg_write` in either.
- sw then j → a single `mem_write` cycle; `pc_source=10` with `pc_en=1` in JUMP; `reg_write` never asserted.
- Opcode 111111:
  - with `MC_ILLEGAL_TRAP_EN` → `illegal_op=1` forever and no further `mem_read`;
  - without it → `instr_done` in DECODE and `mem_read` in the next cycle.
- `rst` pulsed in ALUWB → `reg_write` drops asynchronously, and FETCH resumes after release.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: states, opcodes, mux codes
// and the packed control vector produced by mc_ctrl_decode.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_en;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational output decode: (state, mem_ready, zero) -> datapath control vector.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [3:0]        i_state,
  input  logic              i_mem_ready,
  input  logic              i_zero,
  input  logic              i_nop_retire,
  output logic [CTRL_W-1:0] o_ctrl
);

  ctrl_t w_ctrl;

  always_comb begin
    w_ctrl = '0;
    case (state_t'(i_state))
      S_FETCH: begin
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.alu_src_b = SRCB_FOUR;
        w_ctrl.ir_write  = i_mem_ready;
        w_ctrl.pc_en     = i_mem_ready;
      end
      S_DECODE: begin
        w_ctrl.alu_src_b  = SRCB_IMM2;
        // unknown opcode retires here as a NOP when trapping is disabled
        w_ctrl.instr_done = i_nop_retire;
      end
      S_MEMADR: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        w_ctrl.i_or_d   = 1'b1;
        w_ctrl.mem_read = 1'b1;
      end
      S_MEMWB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
        w_ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        w_ctrl.i_or_d     = 1'b1;
        w_ctrl.mem_write  = 1'b1;
        w_ctrl.instr_done = i_mem_ready;
      end
      S_EXEC: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.reg_dst    = 1'b1;
        w_ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        w_ctrl.alu_src_a  = 1'b1;
        w_ctrl.alu_op     = ALU_SUB;
        w_ctrl.pc_source  = PCSRC_ALUOUT;
        w_ctrl.pc_en      = i_zero;
        w_ctrl.instr_done = 1'b1;
      end
      S_ADDIEX: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
      end
      S_ADDIWB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.instr_done = 1'b1;
      end
      S_JUMP: begin
        w_ctrl.pc_source  = PCSRC_JUMP;
        w_ctrl.pc_en      = 1'b1;
        w_ctrl.instr_done = 1'b1;
      end
      default: w_ctrl = '0;
    endcase
  end

  assign o_ctrl = w_ctrl;

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-subset control unit: state register plus next-state logic.
// Define MC_ILLEGAL_TRAP_EN to lock into a TRAP state on unknown opcodes.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int OPC_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             instr_done,
  output logic             illegal_op
);

  state_t            r_state;
  state_t            w_state_next;
  logic              w_op_known;
  logic              w_nop_retire;
  logic [CTRL_W-1:0] w_ctrl_vec;
  ctrl_t             w_out;

  assign w_op_known = (opcode == OPC_W'(OP_RTYPE)) || (opcode == OPC_W'(OP_LW))   ||
                      (opcode == OPC_W'(OP_SW))    || (opcode == OPC_W'(OP_BEQ))  ||
                      (opcode == OPC_W'(OP_ADDI))  || (opcode == OPC_W'(OP_J));

`ifdef MC_ILLEGAL_TRAP_EN
  assign w_nop_retire = 1'b0;
  assign illegal_op   = ~rst & (r_state == S_TRAP);
`else
  assign w_nop_retire = ~w_op_known;
  assign illegal_op   = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FETCH:  if (mem_ready) w_state_next = S_DECODE;
      S_DECODE: begin
        if ((opcode == OPC_W'(OP_LW)) || (opcode == OPC_W'(OP_SW))) w_state_next = S_MEMADR;
        else if (opcode == OPC_W'(OP_RTYPE)) w_state_next = S_EXEC;
        else if (opcode == OPC_W'(OP_BEQ))   w_state_next = S_BRANCH;
        else if (opcode == OPC_W'(OP_ADDI))  w_state_next = S_ADDIEX;
        else if (opcode == OPC_W'(OP_J))     w_state_next = S_JUMP;
`ifdef MC_ILLEGAL_TRAP_EN
        else                                 w_state_next = S_TRAP;
`else
        else                                 w_state_next = S_FETCH;
`endif
      end
      S_MEMADR: w_state_next = (opcode == OPC_W'(OP_LW)) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) w_state_next = S_MEMWB;
      S_MEMWB:  w_state_next = S_FETCH;
      S_MEMWR:  if (mem_ready) w_state_next = S_FETCH;
      S_EXEC:   w_state_next = S_ALUWB;
      S_ALUWB:  w_state_next = S_FETCH;
      S_BRANCH: w_state_next = S_FETCH;
      S_ADDIEX: w_state_next = S_ADDIWB;
      S_ADDIWB: w_state_next = S_FETCH;
      S_JUMP:   w_state_next = S_FETCH;
      S_TRAP:   w_state_next = S_TRAP;
      default:  w_state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_state_next;
  end

  mc_ctrl_decode u_decode (
    .i_state      (r_state),
    .i_mem_ready  (mem_ready),
    .i_zero       (zero),
    .i_nop_retire (w_nop_retire),
    .o_ctrl       (w_ctrl_vec)
  );

  // reset masks the decode immediately so no strobe survives the reset edge
  assign w_out = rst ? '0 : ctrl_t'(w_ctrl_vec);

  assign pc_en      = w_out.pc_en;
  assign i_or_d     = w_out.i_or_d;
  assign mem_read   = w_out.mem_read;
  assign mem_write  = w_out.mem_write;
  assign ir_write   = w_out.ir_write;
  assign reg_write  = w_out.reg_write;
  assign mem_to_reg = w_out.mem_to_reg;
  assign reg_dst    = w_out.reg_dst;
  assign alu_src_a  = w_out.alu_src_a;
  assign alu_src_b  = w_out.alu_src_b;
  assign alu_op     = w_out.alu_op;
  assign pc_source  = w_out.pc_source;
  assign instr_done = w_out.instr_done;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: per-instruction timelines are expanded into
// expected per-cycle output vectors and retire latencies, checked by a monitor.
module tb_mc_control_fsm;

  typedef struct packed {
    logic       pc_en;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ev_t;

  typedef struct {
    logic [5:0] op;
    logic       z;
    logic       mr;
    ev_t        e;
  } step_t;

  localparam logic [5:0] K_R = 6'b000000, K_LW = 6'b100011, K_SW = 6'b101011;
  localparam logic [5:0] K_BEQ = 6'b000100, K_ADDI = 6'b001000, K_J = 6'b000010;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_en, i_or_d, mem_read, mem_write, ir_write, reg_write;
  logic       mem_to_reg, reg_dst, alu_src_a, instr_done, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;

  always #5 clk = ~clk;

  mc_control_fsm #(.OPC_W(6)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .reg_dst(reg_dst), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source), .instr_done(instr_done),
    .illegal_op(illegal_op)
  );

  ev_t act;
  assign act = {pc_en, i_or_d, mem_read, mem_write, ir_write, reg_write, mem_to_reg,
                reg_dst, alu_src_a, alu_src_b, alu_op, pc_source, instr_done, illegal_op};

  ev_t exp_q[$];
  int  lat_q[$];
  int  n_checks = 0;
  int  n_pass = 0;

  // monitor: compare every cycle that has an expectation; check retire latency on instr_done
  ev_t mon_e;
  int  mon_l;
  int  cyc_cnt = 0;
  initial forever begin
    @(negedge clk);
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_checks++;
      if (act === mon_e) n_pass++;
      else $display("FAIL outputs t=%0t: actual=%h required=%h", $time, act, mon_e);
    end
    if (rst) cyc_cnt = 0;
    else begin
      cyc_cnt++;
      if (instr_done === 1'b1) begin
        n_checks++;
        if (lat_q.size() == 0)
          $display("FAIL retire t=%0t: actual=unexpected instr_done required=none", $time);
        else begin
          mon_l = lat_q.pop_front();
          if (mon_l == cyc_cnt) n_pass++;
          else $display("FAIL latency t=%0t: actual=%0d required=%0d", $time, cyc_cnt, mon_l);
        end
        cyc_cnt = 0;
      end
    end
  end

  task automatic cyc(input logic [5:0] op, input logic z, input logic mr, input logic r,
                     input ev_t e);
    @(posedge clk);
    #1;
    opcode = op; zero = z; mem_ready = mr; rst = r;
    exp_q.push_back(e);
  endtask

  function automatic logic [5:0] rop();
    return 6'($urandom_range(0, 63));
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit known(input logic [5:0] op);
    return op == K_R || op == K_LW || op == K_SW || op == K_BEQ || op == K_ADDI || op == K_J;
  endfunction

  // reference timeline for one instruction: fs fetch stalls, ms memory stalls
  task automatic run_instr(input logic [5:0] op, input logic z, input int fs, input int ms,
                           input bit abort);
    step_t sq[$];
    step_t s;
    int    base;
    for (int i = 0; i <= fs; i++) begin
      s.e = '0; s.e.mem_read = 1; s.e.alu_src_b = 2'b01;
      s.mr = (i == fs); s.e.ir_write = s.mr; s.e.pc_en = s.mr;
      s.op = rop(); s.z = rbit(); sq.push_back(s);
    end
    s.e = '0; s.e.alu_src_b = 2'b11; s.e.instr_done = !known(op);
    s.op = op; s.z = rbit(); s.mr = rbit(); sq.push_back(s);
    if (op == K_LW || op == K_SW) begin
      s.e = '0; s.e.alu_src_a = 1; s.e.alu_src_b = 2'b10;
      s.op = op; s.z = rbit(); s.mr = rbit(); sq.push_back(s);
      for (int i = 0; i <= ms; i++) begin
        s.e = '0; s.e.i_or_d = 1; s.mr = (i == ms);
        if (op == K_LW) s.e.mem_read = 1;
        else begin s.e.mem_write = 1; s.e.instr_done = s.mr; end
        s.op = rop(); s.z = rbit(); sq.push_back(s);
      end
      if (op == K_LW) begin
        s.e = '0; s.e.reg_write = 1; s.e.mem_to_reg = 1; s.e.instr_done = 1;
        s.op = rop(); s.z = rbit(); s.mr = rbit(); sq.push_back(s);
      end
    end else if (op == K_R) begin
      s.e = '0; s.e.alu_src_a = 1; s.e.alu_op = 2'b10;
      s.op = rop(); s.z = rbit(); s.mr = rbit(); sq.push_back(s);
      s.e = '0; s.e.reg_write = 1; s.e.reg_dst = 1; s.e.instr_done = 1;
      s.op = rop(); s.z = rbit(); s.mr = rbit(); sq.push_back(s);
    end else if (op == K_ADDI) begin
      s.e = '0; s.e.alu_src_a = 1; s.e.alu_src_b = 2'b10;
      s.op = rop(); s.z = rbit(); s.mr = rbit(); sq.push_back(s);
      s.e = '0; s.e.reg_write = 1; s.e.instr_done = 1;
      s.op = rop(); s.z = rbit(); s.mr = rbit(); sq.push_back(s);
    end else if (op == K_BEQ) begin
      s.e = '0; s.e.alu_src_a = 1; s.e.alu_op = 2'b01; s.e.pc_source = 2'b01;
      s.e.pc_en = z; s.e.instr_done = 1;
      s.op = rop(); s.z = z; s.mr = rbit(); sq.push_back(s);
    end else if (op == K_J) begin
      s.e = '0; s.e.pc_source = 2'b10; s.e.pc_en = 1; s.e.instr_done = 1;
      s.op = rop(); s.z = rbit(); s.mr = rbit(); sq.push_back(s);
    end
    case (op)
      K_LW:        base = 5 + ms;
      K_SW:        base = 4 + ms;
      K_R, K_ADDI: base = 4;
      K_BEQ, K_J:  base = 3;
      default:     base = 2;
    endcase
    if (!abort) lat_q.push_back(base + fs);
    for (int i = 0; i < sq.size(); i++) begin
      if (abort && i == sq.size() - 1) cyc(sq[i].op, sq[i].z, sq[i].mr, 1'b1, '0);
      else cyc(sq[i].op, sq[i].z, sq[i].mr, 1'b0, sq[i].e);
    end
  endtask

  logic [5:0] ops_tbl[6];
  logic [5:0] rnd_op;
  ev_t        trap_e;

  initial begin
    ops_tbl = '{K_R, K_LW, K_SW, K_BEQ, K_ADDI, K_J};
    cyc(6'd0, 1'b0, 1'b1, 1'b1, '0);
    cyc(6'd0, 1'b0, 1'b1, 1'b1, '0);
    run_instr(K_R,    1'b0, 0, 0, 1'b0);
    run_instr(K_LW,   1'b0, 0, 3, 1'b0);
    run_instr(K_BEQ,  1'b1, 0, 0, 1'b0);
    run_instr(K_BEQ,  1'b0, 0, 0, 1'b0);
    run_instr(K_SW,   1'b0, 0, 0, 1'b0);
    run_instr(K_J,    1'b0, 0, 0, 1'b0);
`ifndef MC_ILLEGAL_TRAP_EN
    run_instr(6'b111111, 1'b0, 0, 0, 1'b0);
`endif
    run_instr(K_R,    1'b0, 0, 0, 1'b1);
    run_instr(K_ADDI, 1'b0, 1, 0, 1'b0);
    for (int n = 0; n < 60; n++) begin
      rnd_op = ops_tbl[$urandom_range(0, 5)];
`ifndef MC_ILLEGAL_TRAP_EN
      if ($urandom_range(0, 6) == 0) begin
        rnd_op = rop();
        while (known(rnd_op)) rnd_op = rop();
      end
`endif
      run_instr(rnd_op, rbit(), $urandom_range(0, 2), $urandom_range(0, 3),
                $urandom_range(0, 15) == 0);
    end
`ifdef MC_ILLEGAL_TRAP_EN
    trap_e = '0; trap_e.mem_read = 1; trap_e.alu_src_b = 2'b01; trap_e.ir_write = 1; trap_e.pc_en = 1;
    cyc(rop(), rbit(), 1'b1, 1'b0, trap_e);
    trap_e = '0; trap_e.alu_src_b = 2'b11;
    cyc(6'b111111, rbit(), rbit(), 1'b0, trap_e);
    trap_e = '0; trap_e.illegal_op = 1;
    for (int i = 0; i < 6; i++) cyc(rop(), rbit(), rbit(), 1'b0, trap_e);
    cyc(rop(), rbit(), rbit(), 1'b1, '0);
    run_instr(K_J, 1'b0, 0, 0, 1'b0);
`endif
    @(negedge clk);
    #1;
    n_checks++;
    if (lat_q.size() == 0 && exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: actual=%0d retires/%0d cycles pending required=0/0",
                  lat_q.size(), exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: actual=not finished required=finished");
    $fatal(1, "timeout");
  end

endmodule
